// File: rtl/spi_slave_rx_with_modes.sv
// SPI receive stage: oversamples sclk/mosi/cs in the clk domain, supports all four {cpol,cpha}
// modes, deserialises MSB-first words onto a valid/ready output and flags overrun/framing errors.
module spi_slave_rx_with_modes #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              overrun,
    output logic              frame_err
);
    localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state, state_nxt;
    logic [SYNC_STAGES-1:0]  sclk_sync, mosi_sync, cs_sync;
    logic [DATA_W-2:0]       shreg;
    logic [DATA_W-1:0]       word;
    logic [CW-1:0]           count;
    logic [1:0]              latched_mode;
    logic                    s_cur, s_prev, c_cur, c_prev, mosi_s;
    logic                    rise, fall, cs_fall, cs_rise, samp_edge, last_bit, complete;

    // Idle-safe reset values so the release of reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
        end
    end

    assign s_cur   = sclk_sync[SYNC_STAGES-2];
    assign s_prev  = sclk_sync[SYNC_STAGES-1];
    assign c_cur   = cs_sync[SYNC_STAGES-2];
    assign c_prev  = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-2];

    assign rise    = !s_prev &&  s_cur;
    assign fall    =  s_prev && !s_cur;
    assign cs_fall =  c_prev && !c_cur;
    assign cs_rise = !c_prev &&  c_cur;

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
    assign samp_edge = (state == ACTIVE) &&
                       ((latched_mode[1] == latched_mode[0]) ? rise : fall);
    assign last_bit  = (count == CW'(DATA_W-1));
    assign complete  = samp_edge && last_bit;
    assign word      = {shreg, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg        <= '0;
            count        <= '0;
            latched_mode <= 2'b00;
            dout         <= '0;
            dout_valid   <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            if (dout_valid && dout_ready) dout_valid <= 1'b0;

            if (state == IDLE) begin
                if (cs_fall) begin
                    latched_mode <= mode;
                    shreg        <= '0;
                    count        <= '0;
                end
            end else begin
                // A completing edge wins over a simultaneous cs release.
                if (complete) begin
                    if (!dout_valid || dout_ready) begin
                        dout       <= word;
                        dout_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    count <= '0;
                end else if (cs_rise) begin
                    if (count != '0) frame_err <= 1'b1;
                    count <= '0;
                end else if (samp_edge) begin
                    shreg <= word[DATA_W-2:0];
                    count <= count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_rx_with_modes.sv
// Randomised bench for spi_slave_rx_with_modes: SPI frames built from word lists, checked
// against the expected word stream and error-pulse counts.
module tb_spi_slave_rx_with_modes;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       sclk = 1'b0, mosi = 1'b0, cs = 1'b1, dout_ready = 1'b1;
    logic [7:0] dout;
    logic       dout_valid, busy, overrun, frame_err;

    spi_slave_rx_with_modes #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sclk(sclk), .mosi(mosi), .cs(cs),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int ov_cnt = 0, fe_cnt = 0, ov_exp = 0, fe_exp = 0;
    logic [7:0] got_q[$], exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observe accepted words and error pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid && dout_ready) got_q.push_back(dout);
            if (overrun)   ov_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one cs frame; rst_at >= 0 pulses reset just before that bit index.
    task automatic send_frame(input logic [1:0] m, input bit bits[$], input int half,
                              input int rst_at);
        mode = m;
        sclk = m[1];
        tick(4);
        cs = 1'b0;
        tick(4);
        chk("busy_hi", {31'd0, busy}, 32'd1);
        for (int i = 0; i < bits.size(); i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_outs", {20'd0, dout, dout_valid, busy, overrun, frame_err}, 32'd0);
                cs = 1'b1;
                sclk = m[1];
                tick(2);
                rst_n = 1'b1;
                tick(4);
                return;
            end
            if (!m[0]) begin
                mosi = bits[i];
                tick(half);
                sclk = ~m[1];
                tick(half);
                sclk = m[1];
            end else begin
                sclk = ~m[1];
                mosi = bits[i];
                tick(half);
                sclk = m[1];
                tick(half);
            end
        end
        tick(half);
        cs = 1'b1;
        tick(6);
        chk("busy_lo", {31'd0, busy}, 32'd0);
    endtask

    // Reference: a frame is a list of words plus trailing partial bits; with ready high every
    // full word is delivered once, and any partial tail yields exactly one framing error.
    task automatic run_frame(input logic [1:0] m, input logic [7:0] ws[$], input int extra,
                             input int half);
        bit bits[$];
        foreach (ws[k]) begin
            for (int b = 7; b >= 0; b--) bits.push_back(ws[k][b]);
            exp_q.push_back(ws[k]);
        end
        for (int e = 0; e < extra; e++) bits.push_back(bit'($urandom_range(0, 1)));
        if (extra % 8 != 0) fe_exp++;
        send_frame(m, bits, half, -1);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_cnt"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            chk({tag, "_word"}, {24'd0, got_q[k]}, {24'd0, exp_q[k]});
        chk({tag, "_ovr"}, ov_cnt, ov_exp);
        chk({tag, "_ferr"}, fe_cnt, fe_exp);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] wq[$];
        bit bq[$];

        #1;
        chk("rst_outs0", {20'd0, dout, dout_valid, busy, overrun, frame_err}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        wq = {8'hA5};
        run_frame(2'd0, wq, 0, 2);
        check_rx("m0_a5");

        for (int m = 1; m < 4; m++) begin
            wq = {8'h3C};
            run_frame(2'(m), wq, 0, 2);
            check_rx($sformatf("m%0d_3c", m));
        end

        // Holding register full: second word is dropped with one overrun pulse.
        dout_ready = 1'b0;
        bq.delete();
        for (int b = 7; b >= 0; b--) bq.push_back(bit'((8'h12 >> b) & 1));
        for (int b = 7; b >= 0; b--) bq.push_back(bit'((8'h34 >> b) & 1));
        send_frame(2'd0, bq, 2, -1);
        chk("ovr_dout", {24'd0, dout}, 32'h12);
        chk("ovr_valid", {31'd0, dout_valid}, 32'd1);
        ov_exp = 1;
        dout_ready = 1'b1;
        tick(2);
        chk("ovr_drain", {31'd0, dout_valid}, 32'd0);
        exp_q.push_back(8'h12);
        check_rx("ovr");

        bq.delete();
        for (int b = 0; b < 5; b++) bq.push_back(1'b1);
        send_frame(2'd0, bq, 2, -1);
        fe_exp++;
        chk("ferr_valid", {31'd0, dout_valid}, 32'd0);
        check_rx("ferr");
        wq = {8'h81};
        run_frame(2'd0, wq, 0, 2);
        check_rx("after_ferr");

        bq.delete();
        for (int b = 0; b < 8; b++) bq.push_back(1'b1);
        send_frame(2'd0, bq, 2, 3);
        wq = {8'h5A};
        run_frame(2'd0, wq, 0, 2);
        check_rx("after_rst");

        wq = {8'($urandom)};
        run_frame(2'd0, wq, 0, 2);
        wq = {8'($urandom)};
        run_frame(2'd3, wq, 0, 2);
        check_rx("b2b");

        for (int f = 0; f < 20; f++) begin
            int nw, extra;
            nw = $urandom_range(1, 3);
            extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            wq.delete();
            for (int k = 0; k < nw; k++) wq.push_back(8'($urandom));
            run_frame(2'($urandom_range(0, 3)), wq, extra, $urandom_range(2, 4));
            check_rx("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
